// File: rtl/matmul_sched_pkg.sv
// Shared types and helpers for matmul_request_scheduler.
// Holds the scheduler FSM state enum and the size clamp rule.
package matmul_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } sched_state_t;

    // A size of zero or beyond the maximum selects the full maximum.
    function automatic logic [31:0] clamp_dim(
        input logic [31:0] value,
        input logic [31:0] max
    );
        return ((value == 32'd0) || (value > max)) ? max : value;
    endfunction

endpackage

// File: rtl/matmul_request_scheduler_pair_counter.sv
// Two-level wrapping (row, col) index counter for the request scheduler.
// Walk order is row-major unless SCHED_COL_MAJOR_EN is defined.
module pair_counter #(
    parameter int RA = 5,
    parameter int RB = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    input  logic [RA:0]   rows,
    input  logic [RB:0]   cols,
    output logic [RA-1:0] row,
    output logic [RB-1:0] col,
    output logic          last
);

    logic [RA-1:0] row_q, row_d;
    logic [RB-1:0] col_q, col_d;
    logic          row_end;
    logic          col_end;

    assign row_end = ({1'b0, row_q} == (rows - (RA+1)'(1)));
    assign col_end = ({1'b0, col_q} == (cols - (RB+1)'(1)));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
`ifdef SCHED_COL_MAJOR_EN
            if (row_end) begin
                row_d = '0;
                col_d = col_end ? '0 : col_q + RB'(1);
            end else begin
                row_d = row_q + RA'(1);
            end
`else
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + RA'(1);
            end else begin
                col_d = col_q + RB'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = row_end && col_end;

endmodule

// File: rtl/matmul_request_scheduler.sv
// Credit-throttled (A row, B col) read request sequencer with in-order return check.
// Define SCHED_COL_MAJOR_EN to walk pairs column-major instead of row-major.
module matmul_request_scheduler
    import matmul_sched_pkg::*;
#(
    parameter int  MAX_SIZE_A  = 32,
    parameter int  MAX_SIZE_B  = 32,
    parameter int  MAX_CREDITS = 4,
    localparam int RA          = $clog2(MAX_SIZE_A),
    localparam int RB          = $clog2(MAX_SIZE_B)
) (
    input  logic          inter_refclk,
    input  logic          rst,
    input  logic          start,
    input  logic [RA:0]   a_rows,
    input  logic [RB:0]   b_cols,
    output logic          valid_request,
    output logic [RA-1:0] requested_a_row,
    output logic [RB-1:0] requested_b_col,
    input  logic          valid_out,
    input  logic [RA-1:0] a_addr_out,
    input  logic [RB-1:0] b_addr_out,
    input  logic          credit_return,
    output logic          busy,
    output logic          done,
    output logic          order_error
);

    localparam int CW = $clog2(MAX_CREDITS + 1);
    localparam int NW = RA + RB + 1;

    sched_state_t  state_q, state_d;
    logic [RA:0]   rows_q, rows_d;
    logic [RB:0]   cols_q, cols_d;
    logic [CW-1:0] credits_q, credits_d;
    logic [NW-1:0] ret_cnt_q, ret_cnt_d;
    logic          err_q, err_d;
    logic          done_q, done_d;

    logic [NW-1:0] total;
    logic          issue;
    logic          accept;
    logic          mismatch;
    logic [RA-1:0] iss_row, exp_row;
    logic [RB-1:0] iss_col, exp_col;
    logic          iss_last;
    logic          exp_last_unused;

    assign issue    = (state_q == ISSUE) && (credits_q != '0);
    assign accept   = start && (state_q == IDLE);
    assign total    = NW'(rows_q) * NW'(cols_q);
    assign mismatch = (a_addr_out != exp_row) || (b_addr_out != exp_col);

    pair_counter #(.RA(RA), .RB(RB)) u_issue_cnt (
        .clk     (inter_refclk),
        .rst     (rst),
        .clear   (accept),
        .advance (issue),
        .rows    (rows_q),
        .cols    (cols_q),
        .row     (iss_row),
        .col     (iss_col),
        .last    (iss_last)
    );

    // Expect side advances on every return, matched or not, to stay in lockstep.
    pair_counter #(.RA(RA), .RB(RB)) u_expect_cnt (
        .clk     (inter_refclk),
        .rst     (rst),
        .clear   (accept),
        .advance (valid_out && (state_q != IDLE)),
        .rows    (rows_q),
        .cols    (cols_q),
        .row     (exp_row),
        .col     (exp_col),
        .last    (exp_last_unused)
    );

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        credits_d = credits_q;
        ret_cnt_d = ret_cnt_q;
        err_d     = err_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rows_d    = (RA+1)'(clamp_dim(32'(a_rows), 32'(MAX_SIZE_A)));
                    cols_d    = (RB+1)'(clamp_dim(32'(b_cols), 32'(MAX_SIZE_B)));
                    credits_d = CW'(MAX_CREDITS);
                    ret_cnt_d = '0;
                    err_d     = 1'b0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (issue && iss_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (ret_cnt_q == total) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            if (issue && !credit_return) begin
                credits_d = credits_q - CW'(1);
            end else if (!issue && credit_return) begin
                if (credits_q == CW'(MAX_CREDITS)) err_d = 1'b1;
                else credits_d = credits_q + CW'(1);
            end
            if (valid_out) begin
                ret_cnt_d = ret_cnt_q + NW'(1);
                if (mismatch) err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge inter_refclk) begin
        if (rst) begin
            state_q   <= IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            credits_q <= CW'(MAX_CREDITS);
            ret_cnt_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            credits_q <= credits_d;
            ret_cnt_q <= ret_cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign valid_request   = issue;
    assign requested_a_row = iss_row;
    assign requested_b_col = iss_col;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign order_error     = err_q;

endmodule

// File: tb/tb_matmul_request_scheduler.sv
// Self-checking bench for matmul_request_scheduler with an in-order loader model.
// Build with SCHED_COL_MAJOR_EN defined to check the column-major walk.
module tb_matmul_request_scheduler;

    localparam int RA   = 5;
    localparam int RB   = 5;
    localparam int MAXA = 32;
    localparam int MAXB = 32;
    localparam int MAXC = 4;

    logic          inter_refclk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [RA:0]   a_rows = '0;
    logic [RB:0]   b_cols = '0;
    logic          valid_request;
    logic [RA-1:0] requested_a_row;
    logic [RB-1:0] requested_b_col;
    logic          valid_out = 1'b0;
    logic [RA-1:0] a_addr_out = '0;
    logic [RB-1:0] b_addr_out = '0;
    logic          credit_return = 1'b0;
    logic          busy;
    logic          done;
    logic          order_error;

    matmul_request_scheduler #(
        .MAX_SIZE_A  (MAXA),
        .MAX_SIZE_B  (MAXB),
        .MAX_CREDITS (MAXC)
    ) dut (
        .inter_refclk    (inter_refclk),
        .rst             (rst),
        .start           (start),
        .a_rows          (a_rows),
        .b_cols          (b_cols),
        .valid_request   (valid_request),
        .requested_a_row (requested_a_row),
        .requested_b_col (requested_b_col),
        .valid_out       (valid_out),
        .a_addr_out      (a_addr_out),
        .b_addr_out      (b_addr_out),
        .credit_return   (credit_return),
        .busy            (busy),
        .done            (done),
        .order_error     (order_error)
    );

    always #5 inter_refclk = ~inter_refclk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] req_q[$];
    logic [9:0] pend_q[$];
    int         due_q[$];
    logic [9:0] exp_q[$];

    int cyc = 0;
    int lat_lo = 3;
    int lat_hi = 3;
    bit loader_en, auto_credit, corrupt_first, manual_credit;
    int done_cnt, busy_at_done, err_at_done, ret_total, outstanding, max_out;

    // Expected request order from the problem size alone.
    function automatic void model_seq(input int r, input int c);
        int er;
        int ec;
        er = (r == 0 || r > MAXA) ? MAXA : r;
        ec = (c == 0 || c > MAXB) ? MAXB : c;
        exp_q.delete();
`ifdef SCHED_COL_MAJOR_EN
        for (int j = 0; j < ec; j++)
            for (int i = 0; i < er; i++)
                exp_q.push_back({5'(i), 5'(j)});
`else
        for (int i = 0; i < er; i++)
            for (int j = 0; j < ec; j++)
                exp_q.push_back({5'(i), 5'(j)});
`endif
    endfunction

    task automatic clear_log();
        req_q.delete();
        pend_q.delete();
        due_q.delete();
        done_cnt = 0;
        busy_at_done = 0;
        err_at_done = 0;
        ret_total = 0;
        outstanding = 0;
        max_out = 0;
    endtask

    // One clock: observe outputs at negedge, then drive loader/credit inputs.
    task automatic cycle();
        @(negedge inter_refclk);
        cyc++;
        if (valid_request) begin
            req_q.push_back({requested_a_row, requested_b_col});
            pend_q.push_back({requested_a_row, requested_b_col});
            due_q.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
            outstanding++;
            if (outstanding > max_out) max_out = outstanding;
        end
        if (done) begin
            done_cnt++;
            if (busy) busy_at_done++;
            err_at_done = order_error;
        end
        valid_out = 1'b0;
        credit_return = 1'b0;
        if (loader_en && due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            {a_addr_out, b_addr_out} = pend_q.pop_front();
            if (corrupt_first) begin
                a_addr_out = 5'd0;
                b_addr_out = 5'd1;
                corrupt_first = 1'b0;
            end
            valid_out = 1'b1;
            ret_total++;
            if (auto_credit) begin
                credit_return = 1'b1;
                outstanding--;
            end
        end
        if (manual_credit) begin
            credit_return = 1'b1;
            outstanding--;
            manual_credit = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        loader_en = 1'b0;
        auto_credit = 1'b0;
        corrupt_first = 1'b0;
        manual_credit = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;
        clear_log();
    endtask

    task automatic launch(input int r, input int c, input int budget);
        clear_log();
        model_seq(r, c);
        a_rows = (RA+1)'(r);
        b_cols = (RB+1)'(c);
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < budget && done_cnt == 0; i++) cycle();
        repeat (4) cycle();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++;
        if (valid_request !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid_request: got %b want 0", valid_request);
        end
        n_cmp++;
        if (order_error !== 1'b0) begin
            n_bad++; $display("FAIL reset_order_error: got %b want 0", order_error);
        end
    endtask

    task automatic test_basic_2x3();
        loader_en = 1'b1; auto_credit = 1'b1; lat_lo = 3; lat_hi = 3;
        launch(2, 3, 200);
        n_cmp++;
        if (req_q.size() != 6) begin
            n_bad++; $display("FAIL basic_req_count: got %0d want 6", req_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < req_q.size(); k++) begin
            n_cmp++;
            if (req_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL basic_req[%0d]: got (%0d,%0d) want (%0d,%0d)", k,
                         req_q[k][9:5], req_q[k][4:0], exp_q[k][9:5], exp_q[k][4:0]);
            end
        end
        n_cmp++;
        if (done_cnt != 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        n_cmp++;
        if (busy_at_done != 0) begin n_bad++; $display("FAIL basic_busy_at_done: got 1 want 0"); end
        n_cmp++;
        if (order_error !== 1'b0) begin
            n_bad++; $display("FAIL basic_order_error: got %b want 0", order_error);
        end
    endtask

    task automatic test_credit_stall();
        loader_en = 1'b0; auto_credit = 1'b0; lat_lo = 3; lat_hi = 3;
        clear_log();
        a_rows = 6'd2; b_cols = 6'd3; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (20) cycle();
        n_cmp++;
        if (req_q.size() != MAXC) begin
            n_bad++; $display("FAIL stall_req_count: got %0d want %0d", req_q.size(), MAXC);
        end
        n_cmp++;
        if (valid_request !== 1'b0) begin
            n_bad++; $display("FAIL stall_valid_request: got %b want 0", valid_request);
        end
        manual_credit = 1'b1;
        repeat (12) cycle();
        n_cmp++;
        if (req_q.size() != MAXC + 1) begin
            n_bad++; $display("FAIL stall_after_credit_count: got %0d want %0d", req_q.size(), MAXC + 1);
        end
        n_cmp++;
        if (req_q.size() > MAXC && req_q[MAXC] !== exp_pair(1, 1, 2, 3)) begin
            n_bad++;
            $display("FAIL stall_after_credit_pair: got (%0d,%0d) want (1,1)",
                     req_q[MAXC][9:5], req_q[MAXC][4:0]);
        end
        do_reset();
    endtask

    // Fifth pair of the walk for a rows x cols problem (row-major or column-major).
    function automatic logic [9:0] exp_pair(input int r, input int c, input int nr, input int nc);
        model_seq(nr, nc);
        return exp_q[MAXC];
    endfunction

    task automatic test_order_error();
        loader_en = 1'b1; auto_credit = 1'b1; corrupt_first = 1'b1; lat_lo = 3; lat_hi = 3;
        launch(2, 3, 200);
        n_cmp++;
        if (done_cnt != 1) begin n_bad++; $display("FAIL orderr_done_count: got %0d want 1", done_cnt); end
        n_cmp++;
        if (err_at_done != 1) begin n_bad++; $display("FAIL orderr_at_done: got %0d want 1", err_at_done); end
        n_cmp++;
        if (order_error !== 1'b1) begin
            n_bad++; $display("FAIL orderr_sticky: got %b want 1", order_error);
        end
    endtask

    task automatic test_max_size();
        int bad;
        loader_en = 1'b1; auto_credit = 1'b1; lat_lo = 3; lat_hi = 3;
        launch(0, 40, 4000);
        bad = 0;
        for (int k = 0; k < exp_q.size() && k < req_q.size(); k++)
            if (req_q[k] !== exp_q[k]) bad++;
        n_cmp++;
        if (req_q.size() != 1024) begin
            n_bad++; $display("FAIL max_req_count: got %0d want 1024", req_q.size());
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL max_req_order: got %0d wrong pairs want 0", bad); end
        n_cmp++;
        if (req_q.size() > 0 && req_q[req_q.size()-1] !== 10'h3ff) begin
            n_bad++; $display("FAIL max_last_pair: got %h want 3ff", req_q[req_q.size()-1]);
        end
        n_cmp++;
        if (ret_total != 1024) begin n_bad++; $display("FAIL max_returns: got %0d want 1024", ret_total); end
        n_cmp++;
        if (done_cnt != 1) begin n_bad++; $display("FAIL max_done_count: got %0d want 1", done_cnt); end
        n_cmp++;
        if (order_error !== 1'b0) begin
            n_bad++; $display("FAIL max_order_error: got %b want 0", order_error);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        loader_en = 1'b1; auto_credit = 1'b1; lat_lo = 3; lat_hi = 3;
        clear_log();
        a_rows = 6'd2; b_cols = 6'd3; start = 1'b1;
        cycle();
        start = 1'b0;
        guard = 0;
        while (req_q.size() < 3 && guard < 50) begin cycle(); guard++; end
        n_cmp++;
        if (req_q.size() != 3) begin n_bad++; $display("FAIL rstmid_reach3: got %0d want 3", req_q.size()); end
        rst = 1'b1;
        cycle();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++;
        if (valid_request !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_valid_request: got %b want 0", valid_request);
        end
        rst = 1'b0;
        repeat (10) cycle();
        n_cmp++;
        if (order_error !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_stale_error: got %b want 0", order_error);
        end
        n_cmp++;
        if (done_cnt != 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt); end
        launch(1, 1, 50);
        n_cmp++;
        if (req_q.size() != 1 || req_q[0] !== 10'h000) begin
            n_bad++; $display("FAIL rstmid_1x1_req: got %0d requests want 1 at (0,0)", req_q.size());
        end
        n_cmp++;
        if (done_cnt != 1 || order_error !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_1x1_done: got done %0d err %b want 1 0", done_cnt, order_error);
        end
    endtask

    task automatic test_random();
        int r;
        int c;
        int bad;
        loader_en = 1'b1; auto_credit = 1'b1; lat_lo = 1; lat_hi = 6;
        for (int it = 0; it < 6; it++) begin
            r = int'($urandom_range(7, 1));
            c = int'($urandom_range(7, 1));
            launch(r, c, 400);
            bad = 0;
            for (int k = 0; k < exp_q.size() && k < req_q.size(); k++)
                if (req_q[k] !== exp_q[k]) bad++;
            n_cmp++;
            if (req_q.size() != exp_q.size() || bad != 0) begin
                n_bad++;
                $display("FAIL rand_%0dx%0d_seq: got %0d reqs %0d wrong want %0d reqs 0 wrong",
                         r, c, req_q.size(), bad, exp_q.size());
            end
            n_cmp++;
            if (done_cnt != 1 || order_error !== 1'b0) begin
                n_bad++;
                $display("FAIL rand_%0dx%0d_done: got done %0d err %b want 1 0", r, c, done_cnt, order_error);
            end
            n_cmp++;
            if (max_out > MAXC) begin
                n_bad++; $display("FAIL rand_%0dx%0d_credits: got %0d outstanding want <= %0d", r, c, max_out, MAXC);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_2x3();
        test_credit_stall();
        test_order_error();
        test_max_size();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
